fb_port_arbiter: RTL and testbench

//  Shares the single-port 320x240 RGB frame-buffer (M9) between three requesters: the AlphaBlender
//  (read-modify-write), host/debug pixel writes (buffered), and the SDRAM flush reader in the output path.

---
 rtl/gpu_fb_pkg.sv | 22 ++
 rtl/fb_port_arbiter_if.sv | 48 ++++
 rtl/fb_host_fifo.sv | 52 +++++
 rtl/fb_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_fb_pkg.sv
// Shared frame-buffer types and sizes for the 320x240 RGB pixel store.
// Used by the port arbiter, its host write FIFO and the bus interface.
package gpu_fb_pkg;

    localparam int PIX_ADDR_W   = 17;
    localparam int RGB_W        = 24;
    localparam int FB_PIXELS    = 76800;
    localparam int HOST_ENTRY_W = PIX_ADDR_W + RGB_W;

    typedef enum logic [1:0] {REQ_B, REQ_H, REQ_F, REQ_NONE} fb_req_t;
    typedef enum logic {ARB_FREE, ARB_LOCKED_B} arb_state_t;

    // Round-robin successor in the fixed B -> H -> F ring.
    function automatic fb_req_t rr_next(input fb_req_t r);
        case (r)
            REQ_B:   return REQ_H;
            REQ_H:   return REQ_F;
            default: return REQ_B;
        endcase
    endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester and frame-buffer side signals of the frame-buffer port arbiter.
// master = requesters plus memory model, slave = the arbiter.
interface fb_port_arbiter_if;
    import gpu_fb_pkg::*;

    logic                  b_req;
    logic                  b_we;
    logic                  b_lock;
    logic [PIX_ADDR_W-1:0] b_addr;
    logic [RGB_W-1:0]      b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic                  h_write;
    logic [PIX_ADDR_W-1:0] h_addr;
    logic [RGB_W-1:0]      h_wdata;
    logic                  h_full;
    logic                  h_overflow;
    logic                  f_req;
    logic [PIX_ADDR_W-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [RGB_W-1:0]      rdata;
    logic                  lock_err;
    logic                  mem_rd;
    logic                  mem_we;
    logic [PIX_ADDR_W-1:0] mem_addr;
    logic [RGB_W-1:0]      mem_wdata;
    logic [RGB_W-1:0]      mem_rdata;

    modport master (
        output b_req, b_we, b_lock, b_addr, b_wdata,
        output h_write, h_addr, h_wdata,
        output f_req, f_addr,
        output mem_rdata,
        input  b_gnt, b_rvalid, h_full, h_overflow, f_gnt, f_rvalid,
        input  rdata, lock_err, mem_rd, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        input  h_write, h_addr, h_wdata,
        input  f_req, f_addr,
        input  mem_rdata,
        output b_gnt, b_rvalid, h_full, h_overflow, f_gnt, f_rvalid,
        output rdata, lock_err, mem_rd, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_host_fifo.sv
// Synchronous FIFO buffering host pixel writes as {addr, wdata} entries.
// Writes arriving while full are dropped and latch a sticky overflow flag.
module fb_host_fifo
    import gpu_fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [HOST_ENTRY_W-1:0] wr_data,
    input  logic                    rd,
    output logic [HOST_ENTRY_W-1:0] rd_data,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [HOST_ENTRY_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count;
    logic                    push;
    logic                    pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot for a push.
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr && !full;
    assign pop     = rd && !empty;
    assign rd_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            if (wr && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter sharing the single-port frame buffer between blender, host FIFO and flush reader,
// with a blender lock for atomic read-modify-write and tagged read-data return.
module fb_port_arbiter
    import gpu_fb_pkg::*;
#(
    parameter int HOST_FIFO_DEPTH = 4,
    parameter int READ_LATENCY    = 1,
    parameter int LOCK_MAX        = 16
) (
    input  logic             clk,
    input  logic             reset,
    fb_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t              state;
    arb_state_t              state_nxt;
    fb_req_t                 rr_ptr;
    fb_req_t                 rr_nxt;
    fb_req_t                 winner;
    fb_req_t                 cand;
    fb_req_t                 rd_tag;
    fb_req_t                 tag_exit;
    fb_req_t                 tag_p [READ_LATENCY];
    logic [CNT_W-1:0]        lock_cnt;
    logic [CNT_W-1:0]        lock_cnt_nxt;
    logic                    force_rel;
    logic                    h_empty;
    logic [HOST_ENTRY_W-1:0] h_head;

    function automatic logic is_req(input fb_req_t c, input logic rb, input logic rh, input logic rf);
        case (c)
            REQ_B:   return rb;
            REQ_H:   return rh;
            REQ_F:   return rf;
            default: return 1'b0;
        endcase
    endfunction

    fb_host_fifo #(
        .DEPTH(HOST_FIFO_DEPTH)
    ) u_host_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (bus.h_write),
        .wr_data  ({bus.h_addr, bus.h_wdata}),
        .rd       (winner == REQ_H),
        .rd_data  (h_head),
        .full     (bus.h_full),
        .empty    (h_empty),
        .overflow (bus.h_overflow)
    );

    // Grant selection: B-only while locked, otherwise first requester from rr_ptr.
    always_comb begin
        winner = REQ_NONE;
        cand   = rr_ptr;
        if (!reset) begin
            if (state == ARB_LOCKED_B) begin
                if (bus.b_req) winner = REQ_B;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (winner == REQ_NONE && is_req(cand, bus.b_req, !h_empty, bus.f_req)) winner = cand;
                    cand = rr_next(cand);
                end
            end
        end
    end

    assign bus.b_gnt = (winner == REQ_B);
    assign bus.f_gnt = (winner == REQ_F);

    always_comb begin
        rd_tag = REQ_NONE;
        if (winner == REQ_B && !bus.b_we) rd_tag = REQ_B;
        if (winner == REQ_F)              rd_tag = REQ_F;
    end

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        lock_cnt_nxt = lock_cnt;
        force_rel    = 1'b0;
        case (state)
            ARB_FREE: begin
                lock_cnt_nxt = '0;
                // Taking the lock leaves the pointer alone so B keeps its turn position.
                if (winner == REQ_B && bus.b_lock) state_nxt = ARB_LOCKED_B;
                else if (winner != REQ_NONE)       rr_nxt = rr_next(winner);
            end
            ARB_LOCKED_B: begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
                if (!bus.b_lock) begin
                    state_nxt = ARB_FREE;
                    if (winner == REQ_B) rr_nxt = REQ_H;
                end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                    state_nxt = ARB_FREE;
                    rr_nxt    = REQ_H;
                    force_rel = 1'b1;
                end
            end
            default: state_nxt = ARB_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_FREE;
            rr_ptr       <= REQ_B;
            lock_cnt     <= '0;
            bus.lock_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (force_rel) bus.lock_err <= 1'b1;
        end
    end

    // Read tag pipe: a tag leaves after READ_LATENCY stages, when mem_rdata for that read is present.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_p[i] <= REQ_NONE;
        end else begin
            tag_p[0] <= rd_tag;
            for (int i = 1; i < READ_LATENCY; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    assign tag_exit = tag_p[READ_LATENCY-1];

    // Registered memory access and read-return stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_rd    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.b_rvalid  <= 1'b0;
            bus.f_rvalid  <= 1'b0;
            bus.rdata     <= '0;
        end else begin
            bus.mem_rd <= 1'b0;
            bus.mem_we <= 1'b0;
            case (winner)
                REQ_B: begin
                    bus.mem_addr <= bus.b_addr;
                    if (bus.b_we) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= bus.b_wdata;
                    end else begin
                        bus.mem_rd <= 1'b1;
                    end
                end
                REQ_H: begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= h_head[HOST_ENTRY_W-1 -: PIX_ADDR_W];
                    bus.mem_wdata <= h_head[RGB_W-1:0];
                end
                REQ_F: begin
                    bus.mem_rd   <= 1'b1;
                    bus.mem_addr <= bus.f_addr;
                end
                default: ;
            endcase
            bus.b_rvalid <= (tag_exit == REQ_B);
            bus.f_rvalid <= (tag_exit == REQ_F);
            if (tag_exit == REQ_B || tag_exit == REQ_F) bus.rdata <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios then random traffic, every cycle compared
// against a queue-based model of the arbitration, lock, host FIFO and read-return rules.
module tb_fb_port_arbiter;
    import gpu_fb_pkg::*;

    localparam int DEPTH = 4;
    localparam int RL    = 2;
    localparam int LMAX  = 16;

    typedef struct {
        logic [16:0] addr;
        logic [23:0] data;
    } hw_t;

    typedef struct {
        int          due;
        int          owner;
        logic [16:0] addr;
    } rd_t;

    logic clk;
    logic reset;
    logic [16:0] rd_addr_q;

    fb_port_arbiter_if bus ();

    fb_port_arbiter #(
        .HOST_FIFO_DEPTH(DEPTH),
        .READ_LATENCY   (RL),
        .LOCK_MAX       (LMAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] fb_pix(input logic [16:0] a);
        if (a == 17'h00123) return 24'hA1B2C3;
        return {a[7:0] ^ 8'h3C, a[15:8], 7'h15, a[16]};
    endfunction

    // Frame-buffer model: data for the address presented with mem_rd appears RL-1 cycles later.
    always @(posedge clk) rd_addr_q <= bus.mem_addr;
    assign bus.mem_rdata = fb_pix(rd_addr_q);

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    hw_t hq[$];
    rd_t rq[$];
    int  m_rr;
    bit  m_locked;
    int  m_lock_len;
    bit  m_ovf, m_lerr;
    bit  e_rd, e_we, e_bv, e_fv;
    logic [16:0] e_addr;
    logic [23:0] e_wdata, e_rdata;
    logic seen_b_gnt, seen_f_gnt, seen_f_rvalid, seen_h_full, seen_h_ovf, seen_lerr;
    logic [23:0] seen_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        rq.delete();
        m_rr = 0; m_locked = 0; m_lock_len = 0; m_ovf = 0; m_lerr = 0;
        e_rd = 0; e_we = 0; e_bv = 0; e_fv = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    function automatic int model_winner();
        bit [2:0] r;
        r[0] = bus.b_req;
        r[1] = (hq.size() > 0);
        r[2] = bus.f_req;
        if (reset) return 3;
        if (m_locked) return bus.b_req ? 0 : 3;
        for (int i = 0; i < 3; i++)
            if (r[(m_rr + i) % 3]) return (m_rr + i) % 3;
        return 3;
    endfunction

    task automatic model_step(input int win);
        hw_t h;
        rd_t r;
        bit  was_full;
        if (reset) begin
            model_reset();
        end else begin
            was_full = (hq.size() == DEPTH);
            e_rd = 0;
            e_we = 0;
            case (win)
                0: begin
                    e_addr = bus.b_addr;
                    if (bus.b_we) begin
                        e_we = 1; e_wdata = bus.b_wdata;
                    end else begin
                        e_rd = 1;
                        r.due = cyc + 1 + RL; r.owner = 0; r.addr = bus.b_addr;
                        rq.push_back(r);
                    end
                end
                1: begin
                    h = hq.pop_front();
                    e_we = 1; e_addr = h.addr; e_wdata = h.data;
                end
                2: begin
                    e_rd = 1; e_addr = bus.f_addr;
                    r.due = cyc + 1 + RL; r.owner = 2; r.addr = bus.f_addr;
                    rq.push_back(r);
                end
                default: ;
            endcase
            if (bus.h_write) begin
                if (was_full) m_ovf = 1;
                else begin
                    h.addr = bus.h_addr; h.data = bus.h_wdata;
                    hq.push_back(h);
                end
            end
            if (!m_locked) begin
                if (win == 0 && bus.b_lock) begin
                    m_locked = 1; m_lock_len = 0;
                end else if (win != 3) m_rr = (win + 1) % 3;
            end else begin
                m_lock_len++;
                if (!bus.b_lock) begin
                    m_locked = 0;
                    if (win == 0) m_rr = 1;
                end else if (m_lock_len == LMAX) begin
                    m_locked = 0; m_lerr = 1; m_rr = 1;
                end
            end
            e_bv = 0;
            e_fv = 0;
            if (rq.size() > 0 && rq[0].due == cyc + 1) begin
                r = rq.pop_front();
                e_bv = (r.owner == 0);
                e_fv = (r.owner == 2);
                e_rdata = fb_pix(r.addr);
            end
        end
        cyc++;
    endtask

    task automatic cycle();
        int win;
        @(negedge clk);
        win = model_winner();
        seen_b_gnt = bus.b_gnt; seen_f_gnt = bus.f_gnt; seen_f_rvalid = bus.f_rvalid;
        seen_h_full = bus.h_full; seen_h_ovf = bus.h_overflow; seen_lerr = bus.lock_err;
        seen_rdata = bus.rdata;
        chk("b_gnt", 32'(bus.b_gnt), 32'(win == 0));
        chk("f_gnt", 32'(bus.f_gnt), 32'(win == 2));
        chk("h_full", 32'(bus.h_full), 32'(hq.size() == DEPTH));
        chk("h_overflow", 32'(bus.h_overflow), 32'(m_ovf));
        chk("lock_err", 32'(bus.lock_err), 32'(m_lerr));
        chk("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("rd_we_excl", 32'(bus.mem_rd & bus.mem_we), 32'(0));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        chk("b_rvalid", 32'(bus.b_rvalid), 32'(e_bv));
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(e_fv));
        chk("rdata", 32'(bus.rdata), 32'(e_rdata));
        @(posedge clk);
        model_step(win);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic idle();
        bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0;
        bus.h_write = 0; bus.f_req = 0;
    endtask

    initial begin
        idle();
        bus.b_addr = 17'h00010; bus.b_wdata = 24'h111111;
        bus.h_addr = 17'h00020; bus.h_wdata = 24'h222222;
        bus.f_addr = 17'h00030;

        // 1: reset with every requester active
        reset = 1;
        bus.b_req = 1; bus.f_req = 1; bus.h_write = 1;
        @(posedge clk); #1;
        model_reset();
        run(2);
        chk("t1_reset_b_gnt", 32'(seen_b_gnt), 32'(0));
        chk("t1_reset_h_full", 32'(seen_h_full), 32'(0));
        reset = 0;
        bus.h_write = 0;
        cycle();
        chk("t1_first_gnt_b", 32'(seen_b_gnt), 32'(1));
        run(3);

        // 2: B, one host entry, F all pending
        reset = 1; idle(); cycle(); reset = 0;
        bus.h_write = 1; bus.h_addr = 17'h01234; bus.h_wdata = 24'hC0FFEE;
        cycle();
        bus.h_write = 0;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 17'h00400; bus.b_wdata = 24'h0A0B0C;
        bus.f_req = 1; bus.f_addr = 17'h00500;
        run(8);

        // 3: flush read with known pixel value
        idle(); run(RL + 2);
        bus.f_req = 1; bus.f_addr = 17'h00123;
        cycle();
        chk("t3_f_gnt", 32'(seen_f_gnt), 32'(1));
        bus.f_req = 0;
        run(2);
        cycle();
        chk("t3_f_rvalid", 32'(seen_f_rvalid), 32'(1));
        chk("t3_rdata", 32'(seen_rdata), 32'h00A1B2C3);

        // 4: locked read-modify-write holds off F
        bus.b_req = 1; bus.b_we = 0; bus.b_lock = 1; bus.b_addr = 17'h00777;
        bus.f_req = 1; bus.f_addr = 17'h00888;
        cycle();
        bus.b_req = 0;
        cycle();
        chk("t4_f_stalled", 32'(seen_f_gnt), 32'(0));
        cycle();
        bus.b_req = 1; bus.b_we = 1; bus.b_lock = 0; bus.b_wdata = 24'h010203;
        cycle();
        chk("t4_b_write_gnt", 32'(seen_b_gnt), 32'(1));
        bus.b_req = 0;
        cycle();
        chk("t4_f_gnt_after", 32'(seen_f_gnt), 32'(1));
        idle(); run(4);

        // 5: host burst while B holds the lock
        bus.b_req = 1; bus.b_we = 1; bus.b_lock = 1; bus.b_addr = 17'h00900;
        cycle();
        for (int i = 0; i < 5; i++) begin
            bus.h_write = 1; bus.h_addr = 17'(17'h1F000 + i); bus.h_wdata = 24'(24'h300000 + i);
            cycle();
        end
        bus.h_write = 0;
        cycle();
        chk("t5_h_full", 32'(seen_h_full), 32'(1));
        chk("t5_h_overflow", 32'(seen_h_ovf), 32'(1));
        bus.b_req = 0; bus.b_lock = 0;
        run(7);

        // 6: lock held past LOCK_MAX with H and F waiting
        bus.h_write = 1; bus.h_addr = 17'h0ABCD; bus.h_wdata = 24'h445566;
        bus.b_req = 1; bus.b_we = 0; bus.b_lock = 1; bus.b_addr = 17'h00042;
        bus.f_req = 1; bus.f_addr = 17'h12C00;
        cycle();
        bus.h_write = 0;
        run(24);
        chk("t6_lock_err", 32'(seen_lerr), 32'(1));
        idle();
        reset = 1; cycle(); reset = 0;
        cycle();
        chk("t6_lock_err_clr", 32'(seen_lerr), 32'(0));
        chk("t6_ovf_clr", 32'(seen_h_ovf), 32'(0));

        // reset with reads in flight
        bus.f_req = 1; bus.f_addr = 17'h00123;
        cycle();
        idle(); reset = 1; cycle(); reset = 0;
        run(RL + 2);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            bus.b_req   = ($urandom_range(3) != 0);
            bus.b_we    = $urandom_range(1) == 1;
            bus.b_lock  = ($urandom_range(2) == 0);
            bus.b_addr  = 17'($urandom);
            bus.b_wdata = 24'($urandom);
            bus.h_write = ($urandom_range(2) == 0);
            bus.h_addr  = 17'($urandom);
            bus.h_wdata = 24'($urandom);
            bus.f_req   = $urandom_range(1) == 1;
            bus.f_addr  = 17'($urandom);
            reset       = ($urandom_range(149) == 0);
            cycle();
        end
        reset = 0; idle(); run(RL + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
